// File: rtl/sbqm_queue_ctrl.sv
// Queue controller for the bank SBqM system: it counts people passing the entry and exit
// photocells and derives the estimated waiting time from the queue length and the teller count.
module sbqm_queue_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned MAX_P      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       back_sensor,
    input  logic       front_sensor,
    input  logic [1:0] tcount,
    output logic [2:0] pcount,
    output logic [4:0] wtime,
    output logic       full,
    output logic       empty,
    output logic       alarm
);

    typedef enum logic {StIdle, StBlocked} sens_state_e;

    localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);
    localparam logic [2:0] MaxP    = 3'(MAX_P);

    // Sensor index 0 is the entry (back) photocell, index 1 is the exit (front) photocell.
    logic [1:0]  raw;
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  deb_q, deb_d;
    logic [7:0]  deb_cnt_q [2];
    logic [7:0]  deb_cnt_d [2];
    sens_state_e state_q   [2];
    logic [1:0]  ev_q;

    logic [2:0]  pcount_q, pcount_d;
    logic        alarm_q, alarm_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic [4:0]  wtime_q, wtime_d;
    logic [5:0]  p6, wt6;

    assign raw = {front_sensor, back_sensor};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // A passage is counted when the beam is released, so the event fires on BLOCKED -> IDLE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                state_q[i] <= StIdle;
                ev_q[i]    <= 1'b0;
            end else begin
                ev_q[i] <= 1'b0;
                case (state_q[i])
                    StIdle: begin
                        if (deb_q[i]) begin
                            state_q[i] <= StBlocked;
                        end
                    end
                    StBlocked: begin
                        if (!deb_q[i]) begin
                            state_q[i] <= StIdle;
                            ev_q[i]    <= 1'b1;
                        end
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        pcount_d = pcount_q;
        alarm_d  = 1'b0;
        case (ev_q)
            2'b01: begin
                if (pcount_q < MaxP) begin
                    pcount_d = pcount_q + 3'd1;
                end else begin
                    alarm_d = 1'b1;
                end
            end
            2'b10: begin
                if (pcount_q != 3'd0) begin
                    pcount_d = pcount_q - 3'd1;
                end else begin
                    alarm_d = 1'b1;
                end
            end
            default: ;
        endcase
        full_d  = (pcount_d == MaxP);
        empty_d = (pcount_d == 3'd0);
    end

    assign p6 = {3'b000, pcount_q};

    always_comb begin
        case (tcount)
            2'd1:    wt6 = 6'd3 * (p6 + 6'd1);
            2'd2:    wt6 = ((6'd3 * p6) >> 1) + 6'd3;
            2'd3:    wt6 = p6 + 6'd2;
            default: wt6 = 6'd0;
        endcase
        wtime_d = wt6[4:0];
    end

    // Largest result is 24, so the top bit of the 6-bit datapath is always clear.
    wt_fits_a: assert property (@(posedge clk) wt6[5] == 1'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcount_q <= '0;
            alarm_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            wtime_q  <= '0;
        end else begin
            pcount_q <= pcount_d;
            alarm_q  <= alarm_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            wtime_q  <= wtime_d;
        end
    end

    assign pcount = pcount_q;
    assign wtime  = wtime_q;
    assign full   = full_q;
    assign empty  = empty_q;
    assign alarm  = alarm_q;

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Bench for sbqm_queue_ctrl: directed scenarios followed by random passages, glitches and
// teller changes, all checked against a queue-length model kept in the bench.
module tb_sbqm_queue_ctrl;

    localparam int DEB  = 4;
    localparam int MAXP = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       back_sensor = 1'b0;
    logic       front_sensor = 1'b0;
    logic [1:0] tcount = 2'd3;
    logic [2:0] pcount;
    logic [4:0] wtime;
    logic       full, empty, alarm;

    int checks = 0;
    int failures = 0;
    int alarm_pulses = 0;
    int alarm_wide = 0;
    logic alarm_prev = 1'b0;
    int model_p = 0;
    int model_alarms = 0;

    sbqm_queue_ctrl #(
        .DEB_CYCLES(DEB),
        .MAX_P     (MAXP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .back_sensor (back_sensor),
        .front_sensor(front_sensor),
        .tcount      (tcount),
        .pcount      (pcount),
        .wtime       (wtime),
        .full        (full),
        .empty       (empty),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alarm === 1'b1) alarm_pulses++;
        if (alarm === 1'b1 && alarm_prev === 1'b1) alarm_wide++;
        alarm_prev = alarm;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int wt_model(input int p, input int t);
        case (t)
            1:       return 3 * (p + 1);
            2:       return (3 * p) / 2 + 3;
            3:       return p + 2;
            default: return 0;
        endcase
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".pcount"}, pcount, model_p);
        check({tag, ".full"}, full, (model_p == MAXP) ? 1 : 0);
        check({tag, ".empty"}, empty, (model_p == 0) ? 1 : 0);
        check({tag, ".wtime"}, wtime, wt_model(model_p, int'(tcount)));
        check({tag, ".alarms"}, alarm_pulses, model_alarms);
        check({tag, ".alarm_width"}, alarm_wide, 0);
    endtask

    task automatic passage(input bit bk, input bit fr);
        back_sensor  = bk;
        front_sensor = fr;
        tick(10);
        back_sensor  = 1'b0;
        front_sensor = 1'b0;
        tick(12);
        if (bk && !fr) begin
            if (model_p < MAXP) model_p++;
            else model_alarms++;
        end else if (fr && !bk) begin
            if (model_p > 0) model_p--;
            else model_alarms++;
        end
    endtask

    task automatic glitch(input bit bk, input bit fr, input int len);
        back_sensor  = bk;
        front_sensor = fr;
        tick(len);
        back_sensor  = 1'b0;
        front_sensor = 1'b0;
        tick(10);
    endtask

    task automatic set_tc(input int t);
        tcount = 2'(t);
        tick(1);
        check("tcount_change.wtime", wtime, wt_model(model_p, t));
    endtask

    initial begin
        int lat;
        int r;

        // Reset state, then wtime settles one cycle after release.
        tick(3);
        check("reset.pcount", pcount, 0);
        check("reset.empty", empty, 1);
        check("reset.full", full, 0);
        check("reset.alarm", alarm, 0);
        check("reset.wtime", wtime, 0);
        rst = 1'b0;
        tick(1);
        check("post_reset.wtime", wtime, 2);
        tick(3);
        check_state("idle");

        // Two entries with exact latency from raw fall to pcount update.
        tcount = 2'd1;
        for (int k = 0; k < 2; k++) begin
            back_sensor = 1'b1;
            tick(10);
            back_sensor = 1'b0;
            lat = 0;
            while (int'(pcount) == model_p && lat < 20) begin
                tick(1);
                lat++;
            end
            check("entry_latency", lat, 2 + DEB + 1 + 1);
            model_p++;
            tick(1);
            check("entry.wtime", wtime, (k == 0) ? 6 : 9);
            tick(3);
            check_state("entry");
        end

        glitch(1'b1, 1'b0, 2);
        check_state("glitch");

        // Fill to capacity, then one more entry raises a single alarm.
        tcount = 2'd2;
        while (model_p < MAXP) passage(1'b1, 1'b0);
        check_state("fill");
        check("fill.wtime_const", wtime, 13);
        passage(1'b1, 1'b0);
        check_state("overflow");

        while (model_p > 3) passage(1'b0, 1'b1);
        passage(1'b1, 1'b1);
        check_state("coincident");
        tcount = 2'd1;
        tick(2);
        tcount = 2'd2;
        tick(1);
        check("tc2.wtime", wtime, 7);
        tcount = 2'd3;
        tick(1);
        check("tc3.wtime", wtime, 5);
        tcount = 2'd0;
        tick(1);
        check("tc0.wtime", wtime, 0);

        while (model_p > 0) passage(1'b0, 1'b1);
        passage(1'b0, 1'b1);
        check_state("underflow");

        // Reset while the entry beam is blocked discards the passage.
        tcount = 2'd1;
        passage(1'b1, 1'b0);
        back_sensor = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_p = 0;
        tick(1);
        back_sensor = 1'b0;
        tick(15);
        check_state("reset_mid_passage");

        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                passage(1'b1, 1'b0);
                check_state("rand_entry");
            end else if (r <= 5) begin
                passage(1'b0, 1'b1);
                check_state("rand_exit");
            end else if (r == 6) begin
                passage(1'b1, 1'b1);
                check_state("rand_both");
            end else if (r == 7) begin
                glitch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(1, DEB - 1)));
                check_state("rand_glitch");
            end else begin
                set_tc(int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
